rv32i_core: RTL and testbench
=============================

// Module: rv32i_core
// PURPOSE
// Multicycle RV32I integer CPU with a PicoRV32-style native memory interface.
// Sits next to bram_controller, which serves every instruction fetch, load and store.
// One memory transaction is in flight at a time; no caches, interrupts or CSRs.
// PARAMETERS
// RESET_PC   32'h0000_0000   address of the first instruction fetched after reset
// PORTS
// clk        in   1   single clock, all state updates on rising edge
// reset_n    in   1   reset, asserted when 1 (synchronous, active-high)
// mem_valid  out  1   transaction request, held until accepted
// mem_instr  out  1   1 = current transaction is an instruction fetch
// mem_ready  in   1   memory completes the transaction this cycle
// mem_addr   out  32  word-aligned byte address ({addr[31:2],2'b00})
// mem_wdata  out  32  store data, lane-aligned
// mem_wstrb  out  4   byte-write enables; 4'b0000 = read
// mem_rdata  in   32  read data, valid in the cycle mem_ready=1
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset: mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
//   Reset also sets pc=RESET_PC, clears x1..x31 to 0 and sets state=FETCH.
//   Reset wins over any in-flight transaction, which is abandoned.
// - Handshake: a transaction completes on the first edge where mem_valid&&mem_ready.
//   While mem_valid=1, addr, wdata, wstrb and instr are held stable.
//   mem_valid drops the cycle after completion. mem_ready is ignored while mem_valid=0.
// - FSM: FETCH -> EXEC -> (MEM ->) WB -> FETCH. HALT is terminal until reset.
//   FETCH: valid=1, instr=1, addr=pc, wstrb=0; on completion latch mem_rdata as ir.
//   EXEC: decode ir, read rs1/rs2, compute ALU result / effective address / branch target.
//     Loads and stores go to MEM; everything else goes to WB.
//   MEM: valid=1, instr=0. Loads use wstrb=0 and capture mem_rdata on completion.
//   WB: write rd unless rd=0, then pc <= next_pc.
// - Minimum latency: 3 cycles per non-memory instruction and 4 per load/store,
//   each with zero wait states.
// - ISA: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW.
//   Also ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI and ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
//   FENCE executes as a NOP.
// - Arithmetic: 32-bit wraparound, no overflow detection. Shift amount is the low 5 bits.
//   Immediates are sign-extended per RV32I.
// - AUIPC: rd = pc_of_this_instr + {imm20,12'b0}.
// - Branch and JAL targets: pc + imm. JALR target: (rs1+imm) & ~1.
//   JAL/JALR write pc+4 to rd, with rs1 read before rd is written (rd==rs1 is safe).
// - x0: always reads 0; writes are discarded.
// - Stores: SB uses wstrb=1<<a[1:0] with the byte replicated on all lanes.
//   SH uses wstrb=2'b11<<a[1:0] with the halfword replicated. SW uses wstrb=4'b1111.
// - Loads: select the lane by a[1:0], then sign- or zero-extend.
// - Misalignment: misaligned halfword/word data access, or a branch/jump target with
//   target[1:0]!=0, enters HALT with no memory request and no register write.
// - Other opcodes: unknown opcodes, ECALL, EBREAK and CSR instructions enter HALT.
// - HALT: mem_valid=0 and all outputs hold their last values.
// TESTING
// - Reset: after reset, first fetch is addr=0, mem_instr=1, wstrb=0.
//   A reset pulse mid-fetch restarts fetch at RESET_PC.
// - AUIPC at pc=0x10 with imm20=0x1: x5=0x0000_1010.
//   LUI x6,0xABCDE: x6=0xABCDE000.
// - BEQ x1,x2 with x1=x2=7, offset +8 at pc=0x20: next fetch addr=0x28.
//   With x2=8: next fetch addr=0x24.
// - SB x3=0x1234_56AA to 0x103: wstrb=4'b1000.
//   LB from it returns 0xFFFF_FFAA; LBU returns 0x0000_00AA; SW/LW round-trip is exact.
// - Wait states: hold mem_ready=0 for 3 cycles. addr/wdata/wstrb stay stable,
//   and exactly one transaction is counted.
// - ADDI x0,x0,5 then ADD x1,x0,x0 gives x1=0.
//   JALR to odd target 0x101 lands at 0x100; LW from 0x102 enters HALT, mem_valid=0.

Source files
------------

// File: rtl/rv32i_core.sv
// rv32i_core: multicycle RV32I integer core with a PicoRV32-style native
// memory interface (one transaction in flight, no caches/interrupts/CSRs).
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous reset, asserted when 1
//   mem_valid  request, held until mem_ready completes it
//   mem_instr  1 = instruction fetch
//   mem_ready  memory completes the transaction this cycle
//   mem_addr   word-aligned byte address
//   mem_wdata  lane-replicated store data
//   mem_wstrb  byte write enables, 4'b0000 = read
//   mem_rdata  read data, valid with mem_ready
//
// Instruction flow: FETCH -> EXEC -> (MEM ->) WB -> FETCH. WB launches the
// next fetch directly and EXEC launches the data access directly, so the
// zero-wait-state cost is 3 cycles (4 with a memory access).
module rv32i_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;
   state_t state, state_next;

   logic [31:0] pc, ir, res_r, npc_r;
   logic        wr_r;
   logic [1:0]  alo_r;
   logic [31:0] regs [1:31];

   logic [6:0]  opc;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1v, rs2v, pc_plus4;

   assign opc   = ir[6:0];
   assign rd    = ir[11:7];
   assign f3    = ir[14:12];
   assign rs1   = ir[19:15];
   assign rs2   = ir[24:20];
   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u = {ir[31:12], 12'd0};
   assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   assign rs1v  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2v  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
   assign pc_plus4 = pc + 32'd4;

   function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (fn)
         3'd0:    alu = alt ? a - b : a + b;
         3'd1:    alu = a << b[4:0];
         3'd2:    alu = {31'd0, sa < sb};
         3'd3:    alu = {31'd0, a < b};
         3'd4:    alu = a ^ b;
         3'd5:    alu = alt ? $unsigned(sa >>> b[4:0]) : a >> b[4:0];
         3'd6:    alu = a | b;
         default: alu = a & b;
      endcase
   endfunction

   // Lane select followed by sign/zero extension of load data.
   function automatic logic [31:0] load_fmt(input logic [2:0] fn, input logic [1:0] lo,
                                            input logic [31:0] d);
      logic [31:0] sh;
      sh = d >> {lo, 3'b000};
      case (fn)
         3'd0:    load_fmt = {{24{sh[7]}}, sh[7:0]};
         3'd1:    load_fmt = {{16{sh[15]}}, sh[15:0]};
         3'd4:    load_fmt = {24'd0, sh[7:0]};
         3'd5:    load_fmt = {16'd0, sh[15:0]};
         default: load_fmt = d;
      endcase
   endfunction

   // Execute-stage decode and address/target computation
   logic [31:0] ex_res, ex_npc, ex_addr, ex_wdata, tgt;
   logic [3:0]  ex_wstrb;
   logic        ex_wr, ex_mem, ex_halt, taken;

   always_comb begin
      ex_res   = 32'd0;
      ex_npc   = pc_plus4;
      ex_addr  = rs1v + imm_i;
      ex_wdata = 32'd0;
      ex_wstrb = 4'b0000;
      ex_wr    = 1'b0;
      ex_mem   = 1'b0;
      ex_halt  = 1'b0;
      tgt      = 32'd0;
      taken    = 1'b0;
      case (opc)
         7'h37: begin ex_res = imm_u;      ex_wr = 1'b1; end
         7'h17: begin ex_res = pc + imm_u; ex_wr = 1'b1; end
         7'h6f: begin
            tgt = pc + imm_j;
            ex_res = pc_plus4; ex_wr = 1'b1; ex_npc = tgt;
            ex_halt = (tgt[1:0] != 2'b00);
         end
         7'h67: begin
            tgt = (rs1v + imm_i) & ~32'd1;
            ex_res = pc_plus4; ex_wr = 1'b1; ex_npc = tgt;
            ex_halt = (tgt[1:0] != 2'b00) || (f3 != 3'd0);
         end
         7'h63: begin
            tgt = pc + imm_b;
            case (f3)
               3'd0:    taken = (rs1v == rs2v);
               3'd1:    taken = (rs1v != rs2v);
               3'd4:    taken = ($signed(rs1v) <  $signed(rs2v));
               3'd5:    taken = ($signed(rs1v) >= $signed(rs2v));
               3'd6:    taken = (rs1v <  rs2v);
               3'd7:    taken = (rs1v >= rs2v);
               default: ex_halt = 1'b1;
            endcase
            if (taken) begin
               ex_npc = tgt;
               if (tgt[1:0] != 2'b00) ex_halt = 1'b1;
            end
         end
         7'h03: begin
            ex_mem = 1'b1; ex_wr = 1'b1;
            case (f3)
               3'd0, 3'd4: ;
               3'd1, 3'd5: ex_halt = ex_addr[0];
               3'd2:       ex_halt = (ex_addr[1:0] != 2'b00);
               default:    ex_halt = 1'b1;
            endcase
         end
         7'h23: begin
            ex_addr = rs1v + imm_s;
            ex_mem  = 1'b1;
            case (f3)
               3'd0: begin
                  ex_wstrb = 4'b0001 << ex_addr[1:0];
                  ex_wdata = {4{rs2v[7:0]}};
               end
               3'd1: begin
                  ex_halt  = ex_addr[0];
                  ex_wstrb = 4'b0011 << ex_addr[1:0];
                  ex_wdata = {2{rs2v[15:0]}};
               end
               3'd2: begin
                  ex_halt  = (ex_addr[1:0] != 2'b00);
                  ex_wstrb = 4'b1111;
                  ex_wdata = rs2v;
               end
               default: ex_halt = 1'b1;
            endcase
         end
         // Only SRAI uses bit 30 among the immediate ALU ops.
         7'h13: begin ex_res = alu(f3, (f3 == 3'd5) && ir[30], rs1v, imm_i); ex_wr = 1'b1; end
         7'h33: begin ex_res = alu(f3, ir[30], rs1v, rs2v); ex_wr = 1'b1; end
         7'h0f: ;
         default: ex_halt = 1'b1;
      endcase
      if (ex_halt) begin
         ex_mem = 1'b0;
         ex_wr  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) state <= FETCH;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH:   if (mem_valid && mem_ready) state_next = EXEC;
         EXEC:    state_next = ex_halt ? HALT : (ex_mem ? MEM : WB);
         MEM:     if (mem_valid && mem_ready) state_next = WB;
         WB:      state_next = FETCH;
         default: state_next = HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         pc        <= RESET_PC;
         ir        <= 32'd0;
         res_r     <= 32'd0;
         npc_r     <= 32'd0;
         wr_r      <= 1'b0;
         alo_r     <= 2'b00;
         mem_valid <= 1'b0;
         mem_instr <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_wstrb <= 4'b0000;
         for (int i = 1; i < 32; i++) regs[i] <= 32'd0;
      end else begin
         case (state)
            FETCH: begin
               // Only taken right after reset; WB normally launches the fetch.
               if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_instr <= 1'b1;
                  mem_addr  <= {pc[31:2], 2'b00};
                  mem_wstrb <= 4'b0000;
               end else if (mem_ready) begin
                  ir        <= mem_rdata;
                  mem_valid <= 1'b0;
               end
            end
            EXEC: begin
               res_r <= ex_res;
               npc_r <= ex_npc;
               wr_r  <= ex_wr && (rd != 5'd0);
               alo_r <= ex_addr[1:0];
               if (ex_mem) begin
                  mem_valid <= 1'b1;
                  mem_instr <= 1'b0;
                  mem_addr  <= {ex_addr[31:2], 2'b00};
                  mem_wstrb <= ex_wstrb;
                  mem_wdata <= ex_wdata;
               end
            end
            MEM: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (mem_wstrb == 4'b0000) res_r <= load_fmt(f3, alo_r, mem_rdata);
               end
            end
            WB: begin
               if (wr_r) regs[rd] <= res_r;
               pc        <= npc_r;
               mem_valid <= 1'b1;
               mem_instr <= 1'b1;
               mem_addr  <= {npc_r[31:2], 2'b00};
               mem_wstrb <= 4'b0000;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed testbench for rv32i_core: a small program is loaded into a bench
// memory, run with zero and stretched wait states, and its stored results,
// fetch trace and transaction counts are compared with hand-computed values.
module tb_rv32i_core;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_valid, mem_instr, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   logic        ready_en;
   logic        ld_we;
   logic [9:0]  ld_idx;
   logic [31:0] ld_dat;
   logic        log_clr;

   logic [31:0] mem  [0:1023];
   logic [31:0] flog [0:63];
   int n_txn = 0, n_fetch = 0, n_sb = 0;
   int n_checks = 0, n_pass = 0;

   always #5 clk = ~clk;

   assign mem_ready = ready_en;
   assign mem_rdata = mem[mem_addr[11:2]];

   rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (ld_we) mem[ld_idx] <= ld_dat;
      else if (mem_valid && mem_ready) begin
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (log_clr) begin
         n_txn <= 0; n_fetch <= 0; n_sb <= 0;
      end else if (mem_valid && mem_ready) begin
         n_txn <= n_txn + 1;
         if (mem_instr) begin
            if (n_fetch < 64) flog[n_fetch] <= mem_addr;
            n_fetch <= n_fetch + 1;
         end
         if (mem_wstrb == 4'b1000) n_sb <= n_sb + 1;
      end
   end

   function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem[a[11:2]];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_we  = 1'b1;
      ld_idx = a[11:2];
      ld_dat = d;
   endtask

   logic [31:0] lw_halt_word;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        seen;

   initial begin
      reset_n  = 1'b1;
      ready_en = 1'b1;
      ld_we    = 1'b0;
      ld_idx   = 10'd0;
      ld_dat   = 32'd0;
      log_clr  = 1'b1;
      lw_halt_word = i_t(12'hAA0, 5'd16, 3'd2, 5'd15, 7'h03);
      repeat (2) @(negedge clk);

      for (int a = 32'h200; a <= 32'h224; a += 4) load(a, 32'hDEAD_BEEF);
      load(32'h100, lw_halt_word);
      load(32'h00, i_t(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));          // ADDI x0,x0,5
      load(32'h04, r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd1));           // ADD x1,x0,x0
      load(32'h08, s_t(12'h200, 5'd1, 5'd0, 3'd2));               // SW x1
      load(32'h0C, i_t(12'd7, 5'd0, 3'd0, 5'd1, 7'h13));          // ADDI x1,x0,7
      load(32'h10, u_t(20'h00001, 5'd5, 7'h17));                  // AUIPC x5,1
      load(32'h14, u_t(20'hABCDE, 5'd6, 7'h37));                  // LUI x6
      load(32'h18, i_t(12'd7, 5'd0, 3'd0, 5'd2, 7'h13));          // ADDI x2,x0,7
      load(32'h1C, 32'h0000_000F);                                // FENCE
      load(32'h20, b_t(13'd8, 5'd2, 5'd1, 3'd0));                 // BEQ taken
      load(32'h24, i_t(12'd1, 5'd0, 3'd0, 5'd8, 7'h13));          // skipped
      load(32'h28, i_t(12'd8, 5'd0, 3'd0, 5'd2, 7'h13));          // ADDI x2,x0,8
      load(32'h2C, b_t(13'd8, 5'd2, 5'd1, 3'd0));                 // BEQ not taken
      load(32'h30, s_t(12'h204, 5'd5, 5'd0, 3'd2));
      load(32'h34, s_t(12'h208, 5'd6, 5'd0, 3'd2));
      load(32'h38, u_t(20'h12345, 5'd3, 7'h37));
      load(32'h3C, i_t(12'h6AA, 5'd3, 3'd0, 5'd3, 7'h13));        // x3=0x123456AA
      load(32'h40, s_t(12'h103, 5'd3, 5'd0, 3'd0));               // SB
      load(32'h44, i_t(12'h103, 5'd0, 3'd0, 5'd9, 7'h03));        // LB
      load(32'h48, i_t(12'h103, 5'd0, 3'd4, 5'd10, 7'h03));       // LBU
      load(32'h4C, s_t(12'h20C, 5'd9, 5'd0, 3'd2));
      load(32'h50, s_t(12'h210, 5'd10, 5'd0, 3'd2));
      load(32'h54, s_t(12'h214, 5'd3, 5'd0, 3'd2));
      load(32'h58, i_t(12'h214, 5'd0, 3'd2, 5'd11, 7'h03));       // LW
      load(32'h5C, s_t(12'h218, 5'd11, 5'd0, 3'd2));
      load(32'h60, r_t(7'h20, 5'd2, 5'd1, 3'd0, 5'd17));          // SUB
      load(32'h64, i_t(12'h404, 5'd6, 3'd5, 5'd18, 7'h13));       // SRAI 4
      load(32'h68, s_t(12'h220, 5'd17, 5'd0, 3'd2));
      load(32'h6C, s_t(12'h224, 5'd18, 5'd0, 3'd2));
      load(32'h70, j_t(21'h10, 5'd12));                           // JAL +0x10
      load(32'h80, s_t(12'h21C, 5'd12, 5'd0, 3'd2));
      load(32'h84, i_t(12'h101, 5'd0, 3'd0, 5'd13, 7'h13));
      load(32'h88, i_t(12'h662, 5'd0, 3'd0, 5'd16, 7'h13));
      load(32'h8C, i_t(12'h000, 5'd13, 3'd0, 5'd14, 7'h67));      // JALR to 0x101
      @(negedge clk);
      ld_we = 1'b0;

      chk("reset_valid", {31'd0, mem_valid}, 32'd0);
      chk("reset_instr", {31'd0, mem_instr}, 32'd0);
      chk("reset_addr", mem_addr, 32'd0);
      chk("reset_wdata", mem_wdata, 32'd0);
      chk("reset_wstrb", {28'd0, mem_wstrb}, 32'd0);

      reset_n = 1'b0;
      log_clr = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = mem_valid;
      end
      chk("first_fetch_seen", {31'd0, seen}, 32'd1);
      chk("first_fetch_addr", mem_addr, 32'd0);
      chk("first_fetch_instr", {31'd0, mem_instr}, 32'd1);
      chk("first_fetch_wstrb", {28'd0, mem_wstrb}, 32'd0);

      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = mem_valid && !mem_instr && (mem_wstrb != 4'b0000) && (mem_addr == 32'h100);
      end
      ready_en = 1'b0;
      chk("sb_seen", {31'd0, seen}, 32'd1);
      chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
      chk("sb_wdata", mem_wdata, 32'hAAAA_AAAA);
      s_addr = mem_addr; s_wdata = mem_wdata; s_wstrb = mem_wstrb;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_valid", {31'd0, mem_valid}, 32'd1);
         chk("wait_hold", {mem_addr ^ s_addr} | {mem_wdata ^ s_wdata} | {28'd0, mem_wstrb ^ s_wstrb}, 32'd0);
      end
      ready_en = 1'b1;

      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         seen = (n_fetch >= 33);
      end
      chk("program_done", {31'd0, seen}, 32'd1);
      repeat (20) @(negedge clk);
      chk("halt_valid", {31'd0, mem_valid}, 32'd0);
      chk("halt_fetches", n_fetch, 32'd33);
      chk("total_txns", n_txn, 32'd47);
      chk("sb_count", n_sb, 32'd1);
      chk("flog0", flog[0], 32'h00);
      chk("flog_auipc", flog[4], 32'h10);
      chk("beq_taken", flog[9], 32'h28);
      chk("beq_not_taken", flog[11], 32'h30);
      chk("jal_target", flog[28], 32'h80);
      chk("jalr_target", flog[32], 32'h100);
      chk("add_x0", rd_mem(32'h200), 32'h0000_0000);
      chk("auipc", rd_mem(32'h204), 32'h0000_1010);
      chk("lui", rd_mem(32'h208), 32'hABCD_E000);
      chk("lb", rd_mem(32'h20C), 32'hFFFF_FFAA);
      chk("lbu", rd_mem(32'h210), 32'h0000_00AA);
      chk("sw", rd_mem(32'h214), 32'h1234_56AA);
      chk("lw_roundtrip", rd_mem(32'h218), 32'h1234_56AA);
      chk("jal_link", rd_mem(32'h21C), 32'h0000_0074);
      chk("sub", rd_mem(32'h220), 32'hFFFF_FFFF);
      chk("srai", rd_mem(32'h224), 32'hFABC_DE00);
      chk("sb_lane", rd_mem(32'h100), lw_halt_word);

      @(negedge clk);
      reset_n = 1'b1;
      log_clr = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      log_clr = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = mem_valid && mem_instr && (mem_addr == 32'h10);
      end
      ready_en = 1'b0;
      chk("refetch_0x10_seen", {31'd0, seen}, 32'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("midfetch_reset_valid", {31'd0, mem_valid}, 32'd0);
      chk("midfetch_reset_addr", mem_addr, 32'd0);
      reset_n = 1'b0;
      ready_en = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = mem_valid;
      end
      chk("restart_seen", {31'd0, seen}, 32'd1);
      chk("restart_addr", mem_addr, 32'd0);
      chk("restart_instr", {31'd0, mem_instr}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
